// File: rtl/div_pkg.sv
// Shared encodings and constants for the radix-4 divider sequencing controller.
package div_pkg;

  localparam int DIV_XLEN = 32;

  // op[0] selects unsigned, op[1] selects remainder
  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_REM  = 2'd2;
  localparam logic [1:0] OP_REMU = 2'd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    POST = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [DIV_XLEN-1:0] DIV0_Q = '1;
  localparam logic [DIV_XLEN-1:0] OVF_A  = 32'h8000_0000;
  localparam logic [DIV_XLEN-1:0] OVF_B  = '1;
  localparam logic [DIV_XLEN-1:0] OVF_Q  = 32'h8000_0000;
  localparam logic [DIV_XLEN-1:0] OVF_R  = '0;

endpackage

// File: rtl/div_ctrl_if.sv
// Request/response bundle between the issue logic (master) and the divider controller (slave).
interface div_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  // Both channels: a transfer happens on a rising edge where valid && ready; the sender
  // holds its payload stable while valid is high, and ready never depends on valid.
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [XLEN-1:0]  req_a;
  logic [XLEN-1:0]  req_b;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [XLEN-1:0]  resp_data;
  logic [TAG_W-1:0] resp_tag;

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag
  );
endinterface

// File: rtl/div_special.sv
// Divide-by-zero and signed-overflow detection with the architecturally defined results.
module div_special
  import div_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            hit,
  output logic [XLEN-1:0] data
);
  logic div0;
  logic ovf;

  assign div0 = (b == '0);
  assign ovf  = !op[0] && (a == XLEN'(OVF_A)) && (b == XLEN'(OVF_B));
  assign hit  = div0 || ovf;

  always_comb begin
    data = '0;
    if (div0) begin
      data = op[1] ? a : XLEN'(DIV0_Q);
    end else if (ovf) begin
      data = op[1] ? XLEN'(OVF_R) : XLEN'(OVF_Q);
    end
  end
endmodule

// File: rtl/div_ctrl.sv
// Sequencing controller for the iterative radix-4 divider: accept, load, step, correct, respond.
module div_ctrl
  import div_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  div_ctrl_if.slave       bus,
  input  logic            flush,
  output logic            dp_load,
  output logic            dp_unsign,
  output logic            dp_iter_en,
  output logic            dp_post,
  input  logic [4:0]      dp_shift,
  input  logic [XLEN-1:0] dp_quot,
  input  logic [XLEN-1:0] dp_rem,
  output state_t          dbg_state
);
  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             sp_hit;
  logic [XLEN-1:0]  sp_data;
  logic [1:0]       op_q;
  logic [TAG_W-1:0] tag_q;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  resp_data_q;
  logic             fresh;
  logic [XLEN-1:0]  post_data;
  logic             unused_shift_lsb;

  // Radix-4 consumes two bits per step, so the lsb of the shift never matters.
  assign unused_shift_lsb = dp_shift[0];

  assign accept    = (state == IDLE) && bus.req_valid && !flush;
  assign dbg_state = state;

  div_special #(.XLEN(XLEN)) u_special (
    .op   (bus.req_op),
    .a    (bus.req_a),
    .b    (bus.req_b),
    .hit  (sp_hit),
    .data (sp_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = sp_hit ? DONE : PREP;
      PREP: state_nxt = flush ? IDLE : ITER;
      ITER: begin
        if (flush)                     state_nxt = IDLE;
        else if (cnt == CNT_W'(1))     state_nxt = POST;
      end
      POST: state_nxt = flush ? IDLE : DONE;
      DONE: if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    dp_load        = 1'b0;
    dp_iter_en     = 1'b0;
    dp_post        = 1'b0;
    dp_unsign      = op_q[0];
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        dp_load       = accept;
        dp_unsign     = accept && bus.req_op[0];
      end
      ITER:    dp_iter_en     = 1'b1;
      POST:    dp_post        = 1'b1;
      DONE:    bus.resp_valid = 1'b1;
      default: ;
    endcase
  end

  // The corrected result appears the cycle after dp_post, which is the first DONE cycle,
  // so it is forwarded that cycle and held from the register afterwards.
  assign post_data     = op_q[1] ? dp_rem : dp_quot;
  assign bus.resp_data = fresh ? post_data : resp_data_q;
  assign bus.resp_tag  = tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      tag_q       <= '0;
      cnt         <= '0;
      resp_data_q <= '0;
      fresh       <= 1'b0;
    end else begin
      fresh <= (state == POST) && !flush;
      if (fresh) resp_data_q <= post_data;
      if (accept) begin
        op_q  <= bus.req_op;
        tag_q <= bus.req_tag;
        if (sp_hit) resp_data_q <= sp_data;
      end
      if (state == PREP) cnt <= flush ? '0 : CNT_W'(dp_shift[4:1]) + CNT_W'(1);
      if (state == ITER) cnt <= flush ? '0 : cnt - CNT_W'(1);
    end
  end

  a_cnt_live: assert property (@(posedge clk) disable iff (!rst_n) !(dp_iter_en && cnt == '0));

endmodule

// File: tb/tb_div_ctrl.sv
// Directed and randomized bench for div_ctrl with a behavioural divider datapath model.
module tb_div_ctrl;
  import div_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam int W     = TAG_W + XLEN;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            dp_load;
  logic            dp_unsign;
  logic            dp_iter_en;
  logic            dp_post;
  logic [4:0]      dp_shift;
  logic [XLEN-1:0] dp_quot;
  logic [XLEN-1:0] dp_rem;
  state_t          dbg_state;

  div_ctrl_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  div_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W), .CNT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .flush      (flush),
    .dp_load    (dp_load),
    .dp_unsign  (dp_unsign),
    .dp_iter_en (dp_iter_en),
    .dp_post    (dp_post),
    .dp_shift   (dp_shift),
    .dp_quot    (dp_quot),
    .dp_rem     (dp_rem),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference divide ----------------
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (!op[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  // ---------------- datapath model ----------------
  logic [4:0]  next_shift;
  logic [31:0] m_q;
  logic [31:0] m_r;

  always @(posedge clk) begin
    if (dp_load) begin
      m_q      <= ref_div({1'b0, bus.req_op[0]}, bus.req_a, bus.req_b);
      m_r      <= ref_div({1'b1, bus.req_op[0]}, bus.req_a, bus.req_b);
      dp_shift <= next_shift;
    end
    dp_quot <= dp_post ? m_q : 32'hDEAD_BEEF;
    dp_rem  <= dp_post ? m_r : 32'hDEAD_BEEF;
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  logic [1:0] last_op;
  logic [4:0] last_shift;
  bit         last_special;
  int         t_acc;

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [4:0] shift,
                       input logic [31:0] exp_data, input bit keep);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
    next_shift    = shift;
    last_op       = op;
    last_shift    = shift;
    last_special  = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    #1;
    chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
    chk("dp_load_pulse", 64'(dp_load), 64'd1);
    chk("dp_unsign_load", 64'(dp_unsign), 64'(op[0]));
    t_acc = cyc;
    if (keep) exp_q.push_back({tag, exp_data});
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic expect_resp(input int hold, input bit flush_done);
    bit           got;
    int           iters;
    int           n_exp;
    logic [W-1:0] exp;
    logic [63:0]  held;
    got   = 1'b0;
    iters = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (dp_iter_en) iters++;
      if (bus.resp_valid) begin
        got = 1'b1;
        break;
      end
    end
    n_exp = last_special ? 0 : int'(last_shift[4:1]) + 1;
    chk("resp_timeout", 64'(got), 64'd1);
    chk("resp_latency", 64'(cyc - t_acc), 64'(last_special ? 1 : n_exp + 3));
    chk("iter_cycles", 64'(iters), 64'(n_exp));
    chk("dp_unsign_hold", 64'(dp_unsign), 64'(last_op[0]));
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    chk("resp_tag_data", 64'({bus.resp_tag, bus.resp_data}), 64'(exp));
    held = 64'({bus.resp_tag, bus.resp_data});
    for (int h = 0; h < hold; h++) begin
      flush = flush_done;
      @(negedge clk);
      #1;
      chk("hold_valid", 64'(bus.resp_valid), 64'd1);
      chk("hold_tag_data", 64'({bus.resp_tag, bus.resp_data}), held);
      chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
    end
    flush          = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    chk({tag, "_dp_outs"}, 64'({dp_load, dp_iter_en, dp_post, dp_unsign}), 64'd0);
    chk({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit          seen;
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    rst_n          = 1'b0;
    flush          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_tag    = '0;
    bus.resp_ready = 1'b0;
    next_shift     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk_idle_outputs("reset");
    chk("reset_resp_data", 64'(bus.resp_data), 64'd0);
    chk("reset_resp_tag", 64'(bus.resp_tag), 64'd0);

    // normal ops across the 1..16 iteration range
    issue(OP_DIV, 32'd100, 32'd7, 5'd3, 5'd9, 32'd14, 1'b1);
    expect_resp(0, 1'b0);
    issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd4, 5'd0, 32'hFFFF_FFFF, 1'b1);
    expect_resp(0, 1'b0);
    issue(OP_REMU, 32'hFFFF_FFF9, 32'd2, 5'd5, 5'd31, 32'h0000_0001, 1'b1);
    expect_resp(0, 1'b0);
    issue(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 5'd2, 32'd0, 1'b1);
    expect_resp(0, 1'b0);

    // special cases complete in one cycle without stepping
    issue(OP_DIVU, 32'h0000_1234, 32'd0, 5'd7, 5'd20, 32'hFFFF_FFFF, 1'b1);
    expect_resp(0, 1'b0);
    issue(OP_REMU, 32'h0000_1234, 32'd0, 5'd8, 5'd20, 32'h0000_1234, 1'b1);
    expect_resp(0, 1'b0);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 5'd6, 32'h8000_0000, 1'b1);
    expect_resp(0, 1'b0);
    issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 5'd6, 32'd0, 1'b1);
    expect_resp(0, 1'b0);

    // backpressure, then back-to-back accept the cycle after the handshake
    issue(OP_DIV, 32'd1000, 32'd3, 5'd11, 5'd7, 32'd333, 1'b1);
    expect_resp(5, 1'b0);
    issue(OP_REM, 32'd1000, 32'd3, 5'd12, 5'd3, 32'd1, 1'b1);
    expect_resp(1, 1'b0);

    // flush during DONE has no effect
    issue(OP_REMU, 32'h0000_1234, 32'd0, 5'd13, 5'd0, 32'h0000_1234, 1'b1);
    expect_resp(2, 1'b1);

    for (int i = 0; i < 6; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      r_b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      issue(r_op, r_a, r_b, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            ref_div(r_op, r_a, r_b), 1'b1);
      expect_resp(int'($urandom_range(0, 2)), 1'b0);
    end

    // flush with a simultaneous request in IDLE
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_DIV;
    bus.req_a     = 32'd9;
    bus.req_b     = 32'd3;
    flush         = 1'b1;
    #1;
    chk("idle_flush_load", 64'(dp_load), 64'd0);
    chk("idle_flush_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    flush         = 1'b0;
    @(negedge clk);
    #1;
    chk_idle_outputs("idle_flush");

    // flush on the third ITER cycle
    issue(OP_DIV, 32'd50, 32'd3, 5'd14, 5'd14, 32'd16, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    chk("flush_at_iter", 64'(dbg_state), 64'(ITER));
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    #1;
    chk_idle_outputs("after_flush");
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.resp_valid || dp_post) seen = 1'b1;
    end
    chk("flush_no_resp", 64'(seen), 64'd0);

    // asynchronous reset in the middle of ITER
    issue(OP_DIVU, 32'd77, 32'd5, 5'd15, 5'd31, 32'd15, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("mid_reset");
    chk("mid_reset_data", 64'(bus.resp_data), 64'd0);
    chk("mid_reset_tag", 64'(bus.resp_tag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(OP_DIV, 32'hFFFF_FF9C, 32'd7, 5'd16, 5'd4, 32'hFFFF_FFF2, 1'b1);
    expect_resp(0, 1'b0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
